// File: rtl/pipeline_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_if
//   Bundle of every signal exchanged between the five-stage datapath and its
//   pipeline controller.
//
//   Hazard inputs (datapath -> controller):
//     idex_memRead, idex_rd       load in EX and its destination register
//     ifid_rs1, ifid_rs2          source registers of the instruction in ID
//   MEM-stage inputs (datapath -> controller, all from EX/MEM):
//     exmem_branch                00 none, 01 beq, 10 bne, 11 jump
//     exmem_zeroFlag              ALU zero result for the branch compare
//     exmem_memAccess             memWrite | memtoReg of the MEM instruction
//     exmem_halt                  halt instruction has reached MEM
//     dmem_ready                  data-memory access completes this cycle
//   Controls (controller -> datapath):
//     pc_write .. exmem_write     pipeline register load enables
//     ifid_flush .. memwb_flush   load a bubble (zeros) into the register
//     pc_sel                      PC loads the branch target
//     halted                      sticky halt status
//     stall_count                 saturating count of memory-wait cycles
//
//   master: datapath side.  slave: controller side.
// ---------------------------------------------------------------------------
interface pipeline_ctrl_if;

    // hazard detection
    logic        idex_memRead;
    logic [4:0]  idex_rd;
    logic [4:0]  ifid_rs1;
    logic [4:0]  ifid_rs2;

    // MEM stage
    logic [1:0]  exmem_branch;
    logic        exmem_zeroFlag;
    logic        exmem_memAccess;
    logic        exmem_halt;
    logic        dmem_ready;

    // register enables
    logic        pc_write;
    logic        ifid_write;
    logic        idex_write;
    logic        exmem_write;

    // bubble inserts
    logic        ifid_flush;
    logic        idex_flush;
    logic        exmem_flush;
    logic        memwb_flush;

    // PC steering and status
    logic        pc_sel;
    logic        halted;
    logic [15:0] stall_count;

    modport master (
        output idex_memRead, idex_rd, ifid_rs1, ifid_rs2,
        output exmem_branch, exmem_zeroFlag, exmem_memAccess, exmem_halt,
        output dmem_ready,
        input  pc_write, ifid_write, idex_write, exmem_write,
        input  ifid_flush, idex_flush, exmem_flush, memwb_flush,
        input  pc_sel, halted, stall_count
    );

    modport slave (
        input  idex_memRead, idex_rd, ifid_rs1, ifid_rs2,
        input  exmem_branch, exmem_zeroFlag, exmem_memAccess, exmem_halt,
        input  dmem_ready,
        output pc_write, ifid_write, idex_write, exmem_write,
        output ifid_flush, idex_flush, exmem_flush, memwb_flush,
        output pc_sel, halted, stall_count
    );

endinterface

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
//   Central stall / flush controller for a five-stage in-order pipeline.
//   Resolves, in priority order, halt, data-memory wait, taken branch and
//   load-use hazards into register enables, bubble inserts and PC steering.
//
//   Ports:
//     clock     rising-edge clock
//     reset_n   asynchronous, active-low reset
//     bus       pipeline_ctrl_if.slave (hazard / MEM inputs, control outputs)
//
//   States:
//     RUN       normal issue; evaluates all hazards each cycle
//     MEM_WAIT  data memory busy; whole pipe frozen, MEM/WB bubbled
//     DRAIN     halt in flight; front end frozen while it reaches WB
//     HALTED    everything frozen until reset
//
//   The state is registered; every output is combinational from state and
//   inputs, then forced low while reset_n is low so nothing loads during reset.
// ---------------------------------------------------------------------------
module pipeline_ctrl (
    input  logic           clock,
    input  logic           reset_n,
    pipeline_ctrl_if.slave bus
);

    localparam logic [1:0] S_RUN      = 2'd0;
    localparam logic [1:0] S_MEM_WAIT = 2'd1;
    localparam logic [1:0] S_DRAIN    = 2'd2;
    localparam logic [1:0] S_HALTED   = 2'd3;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [1:0]  drain_cnt;
    logic [1:0]  drain_cnt_nxt;
    logic [15:0] stall_cnt;

    // ---------------------------------------------------------------------
    // Hazard decode
    // ---------------------------------------------------------------------
    logic branch_taken;
    logic load_use;
    logic mem_busy;

    assign branch_taken = ((bus.exmem_branch == 2'b01) &  bus.exmem_zeroFlag) |
                          ((bus.exmem_branch == 2'b10) & ~bus.exmem_zeroFlag) |
                           (bus.exmem_branch == 2'b11);

    assign load_use = bus.idex_memRead & (bus.idex_rd != 5'd0) &
                      ((bus.idex_rd == bus.ifid_rs1) | (bus.idex_rd == bus.ifid_rs2));

    assign mem_busy = bus.exmem_memAccess & ~bus.dmem_ready;

    // ---------------------------------------------------------------------
    // Next state and raw (pre-reset-gating) controls
    // ---------------------------------------------------------------------
    logic pc_write_c, ifid_write_c, idex_write_c, exmem_write_c;
    logic ifid_flush_c, idex_flush_c, exmem_flush_c, memwb_flush_c;
    logic pc_sel_c, halted_c;

    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;

        pc_write_c    = 1'b1;
        ifid_write_c  = 1'b1;
        idex_write_c  = 1'b1;
        exmem_write_c = 1'b1;
        ifid_flush_c  = 1'b0;
        idex_flush_c  = 1'b0;
        exmem_flush_c = 1'b0;
        memwb_flush_c = 1'b0;
        pc_sel_c      = 1'b0;
        halted_c      = 1'b0;

        case (state)
            S_RUN, S_MEM_WAIT: begin
                if ((state == S_MEM_WAIT) && !bus.dmem_ready) begin
                    // Still waiting: hold every register, keep WB fed with bubbles.
                    pc_write_c    = 1'b0;
                    ifid_write_c  = 1'b0;
                    idex_write_c  = 1'b0;
                    exmem_write_c = 1'b0;
                    memwb_flush_c = 1'b1;
                end else begin
                    // The completing cycle of a wait behaves exactly like RUN,
                    // so the held EX/MEM branch/halt is acted on now.
                    state_nxt = S_RUN;
                    if (bus.exmem_halt) begin
                        pc_write_c    = 1'b0;
                        ifid_write_c  = 1'b0;
                        idex_flush_c  = 1'b1;
                        exmem_flush_c = 1'b1;
                        state_nxt     = S_DRAIN;
                        drain_cnt_nxt = 2'd1;
                    end else if (mem_busy) begin
                        pc_write_c    = 1'b0;
                        ifid_write_c  = 1'b0;
                        idex_write_c  = 1'b0;
                        exmem_write_c = 1'b0;
                        memwb_flush_c = 1'b1;
                        state_nxt     = S_MEM_WAIT;
                    end else if (branch_taken) begin
                        // Squash the three younger instructions; a load-use
                        // stall on a wrong-path instruction is irrelevant.
                        pc_sel_c      = 1'b1;
                        ifid_flush_c  = 1'b1;
                        idex_flush_c  = 1'b1;
                        exmem_flush_c = 1'b1;
                    end else if (load_use) begin
                        // One-cycle bubble: the load leaves EX next cycle, so
                        // the condition clears by itself.
                        pc_write_c    = 1'b0;
                        ifid_write_c  = 1'b0;
                        idex_flush_c  = 1'b1;
                    end
                end
            end

            S_DRAIN: begin
                pc_write_c    = 1'b0;
                ifid_write_c  = 1'b0;
                idex_flush_c  = 1'b1;
                exmem_flush_c = 1'b1;
                // Loaded with 1: one cycle for the halt to reach WB, one more
                // for it to retire, then stop.
                if (drain_cnt == 2'd0) begin
                    state_nxt = S_HALTED;
                end else begin
                    drain_cnt_nxt = drain_cnt - 2'd1;
                end
            end

            default: begin  // S_HALTED
                pc_write_c    = 1'b0;
                ifid_write_c  = 1'b0;
                idex_write_c  = 1'b0;
                exmem_write_c = 1'b0;
                halted_c      = 1'b1;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_RUN;
            drain_cnt <= 2'd0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    // Counts every cycle spent in MEM_WAIT, including the completing one.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= 16'd0;
        end else if ((state == S_MEM_WAIT) && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs: nothing loads, flushes or redirects while reset is held.
    // ---------------------------------------------------------------------
    assign bus.pc_write    = pc_write_c    & reset_n;
    assign bus.ifid_write  = ifid_write_c  & reset_n;
    assign bus.idex_write  = idex_write_c  & reset_n;
    assign bus.exmem_write = exmem_write_c & reset_n;
    assign bus.ifid_flush  = ifid_flush_c  & reset_n;
    assign bus.idex_flush  = idex_flush_c  & reset_n;
    assign bus.exmem_flush = exmem_flush_c & reset_n;
    assign bus.memwb_flush = memwb_flush_c & reset_n;
    assign bus.pc_sel      = pc_sel_c      & reset_n;
    assign bus.halted      = halted_c      & reset_n;
    assign bus.stall_count = stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl
//   Directed scenarios followed by randomized traffic, all checked against a
//   behavioural model of the pipeline controller's rules.
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl;

    logic clock;
    logic reset_n;

    pipeline_ctrl_if bus();

    pipeline_ctrl dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp;
    int n_bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model: pipeline mode as plain flags/counters
    //   m_wait      memory still outstanding
    //   m_drain     drain cycles remaining (0 = not draining)
    //   m_halt      halted
    //   m_stalls    memory-wait cycles seen so far
    // ---------------------------------------------------------------------
    bit m_wait, m_halt;
    int m_drain, m_stalls;
    bit n_wait, n_halt;
    int n_drain, n_stalls;

    // Expected vector order:
    // {pc_write, ifid_write, idex_write, exmem_write,
    //  ifid_flush, idex_flush, exmem_flush, memwb_flush, pc_sel, halted}
    task automatic model_eval(output logic [9:0] e);
        bit pw, fw, dw, xw, ff, df, xf, mf, ps, h;
        bit taken, lu;
        pw = 1; fw = 1; dw = 1; xw = 1;
        ff = 0; df = 0; xf = 0; mf = 0; ps = 0; h = 0;
        taken = (bus.exmem_branch == 2'd1 &&  bus.exmem_zeroFlag) ||
                (bus.exmem_branch == 2'd2 && !bus.exmem_zeroFlag) ||
                (bus.exmem_branch == 2'd3);
        lu = bus.idex_memRead && bus.idex_rd != 0 &&
             (bus.idex_rd == bus.ifid_rs1 || bus.idex_rd == bus.ifid_rs2);

        if (!reset_n) begin
            m_wait = 0; m_halt = 0; m_drain = 0; m_stalls = 0;
            e = '0;
            n_wait = 0; n_halt = 0; n_drain = 0; n_stalls = 0;
            return;
        end

        n_wait = 0; n_halt = m_halt; n_drain = m_drain; n_stalls = m_stalls;
        if (m_halt) begin
            pw = 0; fw = 0; dw = 0; xw = 0; h = 1;
        end else if (m_drain > 0) begin
            pw = 0; fw = 0; df = 1; xf = 1;
            n_drain = m_drain - 1;
            if (n_drain == 0) n_halt = 1;
        end else begin
            if (m_wait) n_stalls = (m_stalls >= 65535) ? 65535 : m_stalls + 1;
            if (m_wait && !bus.dmem_ready) begin
                pw = 0; fw = 0; dw = 0; xw = 0; mf = 1; n_wait = 1;
            end else if (bus.exmem_halt) begin
                pw = 0; fw = 0; df = 1; xf = 1; n_drain = 2;
            end else if (bus.exmem_memAccess && !bus.dmem_ready) begin
                pw = 0; fw = 0; dw = 0; xw = 0; mf = 1; n_wait = 1;
            end else if (taken) begin
                ps = 1; ff = 1; df = 1; xf = 1;
            end else if (lu) begin
                pw = 0; fw = 0; df = 1;
            end
        end
        e = {pw, fw, dw, xw, ff, df, xf, mf, ps, h};
    endtask

    function automatic logic [9:0] observed();
        return {bus.pc_write, bus.ifid_write, bus.idex_write, bus.exmem_write,
                bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.memwb_flush,
                bus.pc_sel, bus.halted};
    endfunction

    // Called at a falling edge with inputs already applied: compare, clock,
    // advance the model, return at the next falling edge.
    task automatic cycle(input string tag);
        logic [9:0] e;
        #1;
        model_eval(e);
        check({tag, ".ctl"}, {22'd0, observed()}, {22'd0, e});
        check({tag, ".cnt"}, {16'd0, bus.stall_count}, m_stalls[31:0]);
        @(posedge clock);
        m_wait = n_wait; m_halt = n_halt; m_drain = n_drain; m_stalls = n_stalls;
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        bus.idex_memRead    = 0;
        bus.idex_rd         = 0;
        bus.ifid_rs1        = 0;
        bus.ifid_rs2        = 0;
        bus.exmem_branch    = 0;
        bus.exmem_zeroFlag  = 0;
        bus.exmem_memAccess = 0;
        bus.exmem_halt      = 0;
        bus.dmem_ready      = 1;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        m_wait = 0; m_halt = 0; m_drain = 0; m_stalls = 0;
        reset_n = 0;
        idle_inputs();
        @(negedge clock);

        // reset state
        cycle("rst0");
        cycle("rst1");
        reset_n = 1;
        cycle("run_idle");
        check("idle_pc_write", {31'd0, bus.pc_write}, 32'd1);

        // load-use, then rd=0 never stalls
        bus.idex_memRead = 1; bus.idex_rd = 5; bus.ifid_rs2 = 5;
        #1 check("lu_pc_write", {31'd0, bus.pc_write}, 32'd0);
        cycle("lu");
        idle_inputs();
        cycle("lu_after");
        bus.idex_memRead = 1; bus.idex_rd = 0; bus.ifid_rs1 = 0;
        cycle("lu_rd0");

        // branch beats load-use; bne with zero set is not taken
        bus.idex_memRead = 1; bus.idex_rd = 7; bus.ifid_rs1 = 7;
        bus.exmem_branch = 2'b01; bus.exmem_zeroFlag = 1;
        #1 check("br_pc_sel", {31'd0, bus.pc_sel}, 32'd1);
        cycle("beq_lu");
        idle_inputs();
        bus.exmem_branch = 2'b10; bus.exmem_zeroFlag = 1;
        cycle("bne_nt");
        bus.exmem_branch = 2'b11;
        cycle("jump");
        idle_inputs();

        // memory wait: 3 low cycles then ready
        bus.exmem_memAccess = 1; bus.dmem_ready = 0;
        repeat (3) cycle("mw_low");
        bus.dmem_ready = 1;
        cycle("mw_done");
        check("mw_count3", {16'd0, bus.stall_count}, 32'd3);
        cycle("mw_zero_stall");
        idle_inputs();
        cycle("mw_idle");

        // saturation
        force dut.stall_cnt = 16'hFFFE;
        #1 release dut.stall_cnt;
        m_stalls = 65534;
        bus.exmem_memAccess = 1; bus.dmem_ready = 0;
        repeat (3) cycle("sat_low");
        bus.dmem_ready = 1;
        cycle("sat_done");
        check("sat_ffff", {16'd0, bus.stall_count}, 32'h0000FFFF);
        idle_inputs();

        // reset in the middle of a memory wait
        bus.exmem_memAccess = 1; bus.dmem_ready = 0;
        repeat (2) cycle("rmw_low");
        reset_n = 0;
        cycle("rmw_rst");
        check("rmw_cnt0", {16'd0, bus.stall_count}, 32'd0);
        reset_n = 1;
        idle_inputs();
        cycle("rmw_after");

        // halt: two drain cycles, then stuck despite stimulus
        bus.exmem_halt = 1;
        cycle("halt");
        bus.exmem_halt = 0;
        repeat (2) cycle("drain");
        check("halted_set", {31'd0, bus.halted}, 32'd1);
        for (int i = 0; i < 12; i++) begin
            bus.exmem_branch = 2'($urandom_range(0, 3));
            bus.exmem_zeroFlag = 1'($urandom_range(0, 1));
            bus.idex_memRead = 1; bus.idex_rd = 3; bus.ifid_rs1 = 3;
            bus.exmem_memAccess = 1'($urandom_range(0, 1));
            bus.dmem_ready = 1'($urandom_range(0, 1));
            cycle("halted_hold");
        end
        reset_n = 0;
        cycle("rh_rst");
        check("rh_halted0", {31'd0, bus.halted}, 32'd0);
        reset_n = 1;
        idle_inputs();
        cycle("rh_after");

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bus.idex_memRead    = 1'($urandom_range(0, 1));
            bus.idex_rd         = 5'($urandom_range(0, 3));
            bus.ifid_rs1        = 5'($urandom_range(0, 3));
            bus.ifid_rs2        = 5'($urandom_range(0, 3));
            bus.exmem_branch    = 2'($urandom_range(0, 3));
            bus.exmem_zeroFlag  = 1'($urandom_range(0, 1));
            bus.exmem_memAccess = ($urandom_range(0, 2) == 0);
            bus.dmem_ready      = ($urandom_range(0, 2) != 0);
            bus.exmem_halt      = ($urandom_range(0, 39) == 0);
            reset_n             = ($urandom_range(0, 79) != 0);
            cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clock input 1 (rising edge), then reset_n input 1 (async assert, active-low).
REQ-002 The block SHALL have these hazard inputs: idex_memRead input 1 (load in EX); idex_rd input 5 (EX destination); ifid_rs1 and ifid_rs2 inputs 5 each (ID sources).
REQ-003 The block SHALL have these MEM-stage inputs, all from EX/MEM: exmem_branch input 2 (00 none, 01 beq, 10 bne, 11 jump); exmem_zeroFlag input 1; exmem_memAccess input 1 (memWrite OR memtoReg); exmem_halt input 1.
REQ-004 The block SHALL have dmem_ready input 1, where 1 means the data-memory access is completing this cycle.
REQ-005 The block SHALL have these enable outputs: pc_write, ifid_write, idex_write, exmem_write; each output 1; 1 = the register loads.
REQ-006 The block SHALL have these flush outputs: ifid_flush, idex_flush, exmem_flush, memwb_flush; each output 1; 1 = the register loads zeros (bubble).
REQ-007 The block SHALL have pc_sel output 1, where 1 = the PC loads the branch target.
REQ-008 The block SHALL have halted output 1, a sticky status bit.
REQ-009 The block SHALL have stall_count output 16, counting memory-wait cycles.

Function
REQ-010 The FSM SHALL have four states: RUN, MEM_WAIT, DRAIN, HALTED; the state SHALL be registered and all outputs SHALL be combinational from state and inputs.
REQ-011 In RUN with no event, all enables SHALL be 1 and all flushes, pc_sel and halted SHALL be 0.
REQ-012 A branch SHALL be taken when (branch==01 & zeroFlag) | (branch==10 & !zeroFlag) | branch==11.
REQ-013 Load-use SHALL be detected when idex_memRead & idex_rd!=0 & (idex_rd==ifid_rs1 | idex_rd==ifid_rs2).
REQ-014 The RUN priority SHALL be halt > memory wait > taken branch > load-use.
REQ-015 On exmem_halt=1 in RUN: pc_write=0, ifid_write=0, idex_flush=1, exmem_flush=1; next state DRAIN; drain counter loaded with 1.
REQ-016 On exmem_memAccess=1 & dmem_ready=0 in RUN: all four enables=0, memwb_flush=1; next state MEM_WAIT.
REQ-017 In MEM_WAIT, the outputs SHALL match REQ-016 every cycle; stall_count SHALL increment once per MEM_WAIT cycle and saturate at 16'hFFFF.
REQ-018 In MEM_WAIT, when dmem_ready=1 the outputs SHALL be as in RUN for that cycle, including branch/halt evaluation of the held EX/MEM contents, and the next state SHALL be RUN (or DRAIN if exmem_halt).
REQ-019 A memory access with dmem_ready=1 already in RUN SHALL cost zero stall cycles and SHALL leave stall_count unchanged.
REQ-020 On a taken branch in RUN: pc_sel=1, ifid_flush=idex_flush=exmem_flush=1, all enables=1; any load-use stall in the same cycle SHALL be suppressed.
REQ-021 On load-use in RUN (no higher-priority event): pc_write=0, ifid_write=0, idex_flush=1, exmem_write=1; the stall SHALL last exactly 1 cycle.
REQ-022 In DRAIN: pc_write=0, ifid_write=0, idex_flush=1, exmem_flush=1, memwb_flush=0; the counter SHALL decrement each cycle, and on 0 the next state SHALL be HALTED (halt reaches WB, then 1 cycle of retirement).
REQ-023 In HALTED: all enables=0, all flushes=0, halted=1; the block SHALL stay in HALTED until reset_n=0.
REQ-024 A taken branch or load-use in DRAIN or HALTED SHALL be ignored.

Reset
REQ-025 While reset_n=0: state=RUN, stall_count=0, drain counter=0, halted=0, pc_sel=0, all flushes=0, all enables=0.
REQ-026 Reset assertion mid-MEM_WAIT or mid-DRAIN SHALL abort immediately; there SHALL be no pending stall after release.
REQ-027 After reset_n rises, the first clock edge SHALL see RUN outputs.

Verification
REQ-028 Bench: idex_memRead=1, idex_rd=5, ifid_rs2=5 for 1 cycle -> pc_write=0, ifid_write=0, idex_flush=1 for exactly 1 cycle; idex_rd=0 -> no stall.
REQ-029 Bench: exmem_branch=01, zeroFlag=1 together with a load-use match -> pc_sel=1, three flushes=1, pc_write=1; exmem_branch=10, zeroFlag=1 -> no flush.
REQ-030 Bench: exmem_memAccess=1, dmem_ready low for 3 cycles then high -> 3 cycles with all enables 0 and memwb_flush 1; stall_count=3; RUN on the 4th cycle.
REQ-031 Bench: exmem_halt=1 -> DRAIN for 2 cycles, then halted=1 and all enables 0 held for 10+ cycles despite branch/hazard stimulus.
REQ-032 Bench: force stall_count to 16'hFFFE, then 3 wait cycles -> stall_count=16'hFFFF.
REQ-033 Bench: reset_n pulsed low during MEM_WAIT and during HALTED -> immediate RUN outputs except enables=0 while reset is low; halted=0, stall_count=0.
